calc_key_ctrl: RTL and testbench
================================

Name: calc_key_ctrl

Overview:
- Keypad sequencing controller that sits between the debounced keypad decoder and the two-operand decimal calculator datapath.
- Turns key-press pulses into the datapath's digit-shift pulses (key_in, num_valid), operand select (mode_num_dis) and operation select (mode_arith).
- Enforces a 2-digit limit per operand.
- The datapath's digit shifters are cleared only by reset, so this block clears an operand by injecting two zero digits; it also drives the display source select.

Parameters:
- TIMEOUT_CYC, 100000000: idle cycles in S_RESULT before automatic clear; used only with IDLE_TIMEOUT_EN; counter width = clog2(TIMEOUT_CYC+1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- key_valid  input  1  one-cycle pulse, key_code valid
- key_code  input  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 equals, 14 unused, 15 clear
- key_out  output  4  digit to datapath shifter
- num_valid  output  1  one-cycle shift strobe to datapath
- mode_num_dis  output  1  0 = operand A shifter, 1 = operand B shifter
- mode_arith  output  2  0 add, 1 sub, 2 mul (3 never driven)
- disp_sel  output  2  0 show A, 1 show B, 2 show result
- busy  output  1  high while clear/inject sequence runs
- key_drop  output  1  one-cycle pulse when a key_valid arrives while busy

Behaviour:
- All outputs registered. Reset values: state S_ENTER_A, key_out=0, num_valid=0, mode_num_dis=0, mode_arith=0, disp_sel=0, busy=0, key_drop=0, digit_cnt=0, pend_vld=0.
- Reset mid-sequence aborts immediately. The datapath resets in the same event, so no clear is issued.
- Key acceptance:
  - Accepted only when key_valid=1 and busy=0.
  - Response appears on outputs the cycle after acceptance (latency 1).
  - key_valid while busy=1: key discarded, key_drop=1 next cycle.
  - Code 14 is ignored in every state.
- S_ENTER_A (mode_num_dis=0, disp_sel=0):
  - Digit with digit_cnt<2: num_valid=1, key_out=digit, digit_cnt+1.
  - Digit with digit_cnt=2: ignored.
  - 10/11/12: mode_arith <= code-10, mode_num_dis <= 1, disp_sel <= 1, go S_CLR_B.
  - 13: ignored.
  - 15: go S_CLR_A.
- S_ENTER_B (mode_num_dis=1, disp_sel=1):
  - Digits: same rule as S_ENTER_A.
  - 10/11/12: overwrite mode_arith, stay.
  - 13: disp_sel <= 2, go S_RESULT.
  - 15: go S_CLR_A.
- S_RESULT (disp_sel=2, mode_arith held):
  - Digit: store it in pend_digit, pend_vld=1, go S_CLR_A.
  - 10-13: ignored.
  - 15: go S_CLR_A with pend_vld=0.
- S_CLR_A:
  - mode_num_dis <= 0, busy=1.
  - Two consecutive cycles of num_valid=1, key_out=0 (internal clr_cnt 0..1).
  - Then disp_sel <= 0, digit_cnt <= 0. Go S_INJECT if pend_vld, else S_ENTER_A.
- S_CLR_B:
  - mode_num_dis=1, busy=1.
  - Two cycles of num_valid=1, key_out=0.
  - Then digit_cnt <= 0, go S_ENTER_B.
- S_INJECT:
  - busy=1 for one cycle: num_valid=1, key_out=pend_digit, digit_cnt <= 1, pend_vld <= 0.
  - Then S_ENTER_A.
- busy falls in the same cycle the state returns to S_ENTER_A/S_ENTER_B, so keys are accepted that cycle.
- mode_num_dis never changes in a cycle where num_valid=1 unless the new value is the one that strobe targets.
- num_valid is never high two cycles in a row outside the clear/inject sequences.

Optional Feature:
- Macro IDLE_TIMEOUT_EN.
- Defined:
  - Counter runs in S_RESULT and resets on any accepted key or on state entry.
  - On reaching TIMEOUT_CYC it forces S_CLR_A with pend_vld=0, then S_ENTER_A with disp_sel=0.
  - A key accepted in the same cycle as expiry wins over the timeout.
- Undefined: no counter; S_RESULT is held until a key arrives.

Test Plan:
- Reset, keys 4,2,+(10),1,7,=(13) -> num_valid pulses with key_out 4,2 (mode_num_dis=0); two zero pulses (mode_num_dis=1, busy=1); then 1,7; mode_arith=0; disp_sel=2 after =.
- Keys 9,9,5 in S_ENTER_A -> exactly two num_valid pulses (9,9); third digit produces no strobe.
- In S_RESULT press 3 -> pulses 0,0 with mode_num_dis=0 then 3; busy high 3 cycles; disp_sel=0; next digit accepted as 2nd digit only.
- key_valid during S_CLR_B -> key_drop=1 one cycle after; no extra num_valid; state reaches S_ENTER_B after exactly 2 clear strobes.
- In S_ENTER_B press 11 then 12 then 13 -> mode_arith 1 then 2, stays 2 in S_RESULT; key 15 -> two zero pulses to A, disp_sel=0.
- With IDLE_TIMEOUT_EN and TIMEOUT_CYC=8: enter S_RESULT, no keys -> S_CLR_A starts after 8 cycles; a key in cycle 8 -> key handled, no timeout clear.

Source files
------------

// File: rtl/calc_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_key_ctrl
// Purpose  : Keypad sequencing controller between the debounced keypad
//            decoder and the two-operand decimal calculator datapath.
//            Turns key pulses into digit-shift strobes, selects the operand
//            shifter and arithmetic operation, limits each operand to two
//            digits, and clears operands by shifting in two zero digits
//            (the datapath shifters are cleared only by reset).
// Ports    : clk          - system clock, all state on rising edge
//            rst_n        - asynchronous active-low reset
//            key_valid    - one-cycle pulse, key_code valid
//            key_code     - 0-9 digit, 10 add, 11 sub, 12 mul, 13 equals,
//                           14 unused, 15 clear
//            key_out      - digit to datapath shifter
//            num_valid    - one-cycle shift strobe to datapath
//            mode_num_dis - 0 = operand A shifter, 1 = operand B shifter
//            mode_arith   - 0 add, 1 sub, 2 mul
//            disp_sel     - 0 show A, 1 show B, 2 show result
//            busy         - high while a clear/inject sequence runs
//            key_drop     - pulse when a key arrives while busy
// Options  : IDLE_TIMEOUT_EN - when defined, S_RESULT clears itself after
//            TIMEOUT_CYC idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module calc_key_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] key_out,
  output logic       num_valid,
  output logic       mode_num_dis,
  output logic [1:0] mode_arith,
  output logic [1:0] disp_sel,
  output logic       busy,
  output logic       key_drop
);

  localparam logic [3:0] c_key_eq   = 4'd13;
  localparam logic [3:0] c_key_clr  = 4'd15;
  localparam logic [1:0] c_disp_a   = 2'd0;
  localparam logic [1:0] c_disp_b   = 2'd1;
  localparam logic [1:0] c_disp_res = 2'd2;

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_RESULT  = 3'd2,
    S_CLR_A   = 3'd3,
    S_CLR_B   = 3'd4,
    S_INJECT  = 3'd5
  } state_t;

  state_t     r_state, w_state;
  logic [3:0] r_key_out, w_key_out;
  logic       r_num_valid, w_num_valid;
  logic       r_mode_num_dis, w_mode_num_dis;
  logic [1:0] r_mode_arith, w_mode_arith;
  logic [1:0] r_disp_sel, w_disp_sel;
  logic       r_busy, w_busy;
  logic       r_key_drop, w_key_drop;
  logic [1:0] r_digit_cnt, w_digit_cnt;
  logic       r_pend_vld, w_pend_vld;
  logic [3:0] r_pend_digit, w_pend_digit;
  logic       r_clr_cnt, w_clr_cnt;

  logic       w_accept, w_is_digit, w_is_op, w_expire, w_start_clr_a;
  logic [1:0] w_op;

  assign w_accept   = key_valid & ~r_busy;
  assign w_is_digit = (key_code <= 4'd9);

  always_comb begin
    w_is_op = 1'b1;
    w_op    = 2'd0;
    case (key_code)
      4'd10:   w_op = 2'd0;
      4'd11:   w_op = 2'd1;
      4'd12:   w_op = 2'd2;
      default: w_is_op = 1'b0;
    endcase
  end

`ifdef IDLE_TIMEOUT_EN
  localparam int unsigned c_tmo_w = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

  logic [c_tmo_w-1:0] r_idle_cnt;

  // Expiry is flagged in the last idle cycle so the clear starts exactly
  // TIMEOUT_CYC cycles after entering S_RESULT; an accepted key that same
  // cycle takes priority in the next-state logic.
  assign w_expire = (r_state == S_RESULT) && (r_idle_cnt == c_tmo_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != S_RESULT) || w_accept) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state        = r_state;
    w_key_out      = r_key_out;
    w_num_valid    = 1'b0;
    w_mode_num_dis = r_mode_num_dis;
    w_mode_arith   = r_mode_arith;
    w_disp_sel     = r_disp_sel;
    w_busy         = r_busy;
    w_key_drop     = key_valid & r_busy;
    w_digit_cnt    = r_digit_cnt;
    w_pend_vld     = r_pend_vld;
    w_pend_digit   = r_pend_digit;
    w_clr_cnt      = r_clr_cnt;
    w_start_clr_a  = 1'b0;

    case (r_state)
      S_ENTER_A, S_ENTER_B: begin
        if (w_accept) begin
          if (w_is_digit) begin
            if (r_digit_cnt < 2'd2) begin
              w_num_valid = 1'b1;
              w_key_out   = key_code;
              w_digit_cnt = r_digit_cnt + 2'd1;
            end
          end else if (w_is_op) begin
            w_mode_arith = w_op;
            if (r_state == S_ENTER_A) begin
              // Switch to operand B and emit the first zero strobe at once;
              // the strobe targets B, so mode_num_dis may change with it.
              w_state        = S_CLR_B;
              w_mode_num_dis = 1'b1;
              w_disp_sel     = c_disp_b;
              w_busy         = 1'b1;
              w_num_valid    = 1'b1;
              w_key_out      = 4'd0;
              w_clr_cnt      = 1'b0;
            end
          end else if (key_code == c_key_eq) begin
            if (r_state == S_ENTER_B) begin
              w_state    = S_RESULT;
              w_disp_sel = c_disp_res;
            end
          end else if (key_code == c_key_clr) begin
            w_pend_vld    = 1'b0;
            w_start_clr_a = 1'b1;
          end
        end
      end

      S_RESULT: begin
        if (w_accept) begin
          if (w_is_digit) begin
            // A digit here starts a new calculation: clear A, then shift
            // the remembered digit in as its first digit.
            w_pend_digit  = key_code;
            w_pend_vld    = 1'b1;
            w_start_clr_a = 1'b1;
          end else if (key_code == c_key_clr) begin
            w_pend_vld    = 1'b0;
            w_start_clr_a = 1'b1;
          end
        end else if (w_expire) begin
          w_pend_vld    = 1'b0;
          w_start_clr_a = 1'b1;
        end
      end

      S_CLR_A: begin
        if (!r_clr_cnt) begin
          w_num_valid = 1'b1;
          w_key_out   = 4'd0;
          w_clr_cnt   = 1'b1;
        end else begin
          w_disp_sel  = c_disp_a;
          w_digit_cnt = 2'd0;
          if (r_pend_vld) begin
            w_state     = S_INJECT;
            w_num_valid = 1'b1;
            w_key_out   = r_pend_digit;
            w_digit_cnt = 2'd1;
            w_pend_vld  = 1'b0;
          end else begin
            w_state = S_ENTER_A;
            w_busy  = 1'b0;
          end
        end
      end

      S_CLR_B: begin
        if (!r_clr_cnt) begin
          w_num_valid = 1'b1;
          w_key_out   = 4'd0;
          w_clr_cnt   = 1'b1;
        end else begin
          w_digit_cnt = 2'd0;
          w_state     = S_ENTER_B;
          w_busy      = 1'b0;
        end
      end

      S_INJECT: begin
        w_state = S_ENTER_A;
        w_busy  = 1'b0;
      end

      default: begin
        w_state = S_ENTER_A;
        w_busy  = 1'b0;
      end
    endcase

    // Common entry into the operand-A clear: first zero strobe goes out
    // together with the switch to the A shifter.
    if (w_start_clr_a) begin
      w_state        = S_CLR_A;
      w_mode_num_dis = 1'b0;
      w_busy         = 1'b1;
      w_num_valid    = 1'b1;
      w_key_out      = 4'd0;
      w_clr_cnt      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_ENTER_A;
      r_key_out      <= 4'd0;
      r_num_valid    <= 1'b0;
      r_mode_num_dis <= 1'b0;
      r_mode_arith   <= 2'd0;
      r_disp_sel     <= c_disp_a;
      r_busy         <= 1'b0;
      r_key_drop     <= 1'b0;
      r_digit_cnt    <= 2'd0;
      r_pend_vld     <= 1'b0;
      r_pend_digit   <= 4'd0;
      r_clr_cnt      <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_key_out      <= w_key_out;
      r_num_valid    <= w_num_valid;
      r_mode_num_dis <= w_mode_num_dis;
      r_mode_arith   <= w_mode_arith;
      r_disp_sel     <= w_disp_sel;
      r_busy         <= w_busy;
      r_key_drop     <= w_key_drop;
      r_digit_cnt    <= w_digit_cnt;
      r_pend_vld     <= w_pend_vld;
      r_pend_digit   <= w_pend_digit;
      r_clr_cnt      <= w_clr_cnt;
    end
  end

  assign key_out      = r_key_out;
  assign num_valid    = r_num_valid;
  assign mode_num_dis = r_mode_num_dis;
  assign mode_arith   = r_mode_arith;
  assign disp_sel     = r_disp_sel;
  assign busy         = r_busy;
  assign key_drop     = r_key_drop;

endmodule
`default_nettype wire

// File: tb/tb_calc_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_key_ctrl
// Purpose  : Directed self-checking bench for calc_key_ctrl. Inputs change
//            on the falling edge; outputs are sampled on the falling edge
//            after the rising edge that produced them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_key_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] key_out;
  logic       num_valid;
  logic       mode_num_dis;
  logic [1:0] mode_arith;
  logic [1:0] disp_sel;
  logic       busy;
  logic       key_drop;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] obs;
  assign obs = {key_out, num_valid, mode_num_dis, mode_arith, disp_sel, busy, key_drop};

  always #5 clk = ~clk;

  calc_key_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_out      (key_out),
    .num_valid    (num_valid),
    .mode_num_dis (mode_num_dis),
    .mode_arith   (mode_arith),
    .disp_sel     (disp_sel),
    .busy         (busy),
    .key_drop     (key_drop)
  );

  task automatic step();
    @(negedge clk);
  endtask

  // One-cycle key pulse; returns on the falling edge after acceptance.
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    repeat (3) step();
    n_checks++;
    if (obs !== 12'h000) $display("FAIL reset_values: got %h want 000", obs);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (obs !== 12'h000) $display("FAIL after_reset_idle: got %h want 000", obs);
    else n_pass++;
    // Reset during a clear must abort it immediately.
    press(4'd15);
    n_checks++;
    if ({num_valid, key_out, busy} !== {1'b1, 4'd0, 1'b1})
      $display("FAIL clr_start: got nv=%b ko=%0d busy=%b want 1 0 1", num_valid, key_out, busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 12'h000) $display("FAIL async_abort: got %h want 000", obs);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    step();
    n_checks++;
    if ({num_valid, busy} !== 2'b00) $display("FAIL no_clr_after_abort: got nv=%b busy=%b want 0 0", num_valid, busy);
    else n_pass++;
  endtask

  task automatic test_basic_calc();
    do_reset();
    press(4'd4);
    n_checks++;
    if ({num_valid, key_out, mode_num_dis, busy} !== {1'b1, 4'd4, 1'b0, 1'b0})
      $display("FAIL digit_a4: got nv=%b ko=%0d mnd=%b busy=%b want 1 4 0 0", num_valid, key_out, mode_num_dis, busy);
    else n_pass++;
    press(4'd2);
    n_checks++;
    if ({num_valid, key_out, mode_num_dis} !== {1'b1, 4'd2, 1'b0})
      $display("FAIL digit_a2: got nv=%b ko=%0d mnd=%b want 1 2 0", num_valid, key_out, mode_num_dis);
    else n_pass++;
    press(4'd10);
    n_checks++;
    if ({num_valid, key_out, mode_num_dis, busy, disp_sel, mode_arith} !== {1'b1, 4'd0, 1'b1, 1'b1, 2'd1, 2'd0})
      $display("FAIL clr_b_1: got nv=%b ko=%0d mnd=%b busy=%b disp=%0d ar=%0d want 1 0 1 1 1 0",
               num_valid, key_out, mode_num_dis, busy, disp_sel, mode_arith);
    else n_pass++;
    step();
    n_checks++;
    if ({num_valid, key_out, mode_num_dis, busy} !== {1'b1, 4'd0, 1'b1, 1'b1})
      $display("FAIL clr_b_2: got nv=%b ko=%0d mnd=%b busy=%b want 1 0 1 1", num_valid, key_out, mode_num_dis, busy);
    else n_pass++;
    step();
    n_checks++;
    if ({num_valid, busy} !== 2'b00) $display("FAIL clr_b_done: got nv=%b busy=%b want 0 0", num_valid, busy);
    else n_pass++;
    press(4'd1);
    n_checks++;
    if ({num_valid, key_out, mode_num_dis} !== {1'b1, 4'd1, 1'b1})
      $display("FAIL digit_b1: got nv=%b ko=%0d mnd=%b want 1 1 1", num_valid, key_out, mode_num_dis);
    else n_pass++;
    press(4'd7);
    n_checks++;
    if ({num_valid, key_out, mode_num_dis} !== {1'b1, 4'd7, 1'b1})
      $display("FAIL digit_b7: got nv=%b ko=%0d mnd=%b want 1 7 1", num_valid, key_out, mode_num_dis);
    else n_pass++;
    press(4'd13);
    n_checks++;
    if ({num_valid, disp_sel, mode_arith, busy} !== {1'b0, 2'd2, 2'd0, 1'b0})
      $display("FAIL equals: got nv=%b disp=%0d ar=%0d busy=%b want 0 2 0 0", num_valid, disp_sel, mode_arith, busy);
    else n_pass++;
  endtask

  // Continues from S_RESULT left by test_basic_calc.
  task automatic test_result_inject();
    press(4'd3);
    n_checks++;
    if ({num_valid, key_out, mode_num_dis, busy, disp_sel} !== {1'b1, 4'd0, 1'b0, 1'b1, 2'd2})
      $display("FAIL inj_clr1: got nv=%b ko=%0d mnd=%b busy=%b disp=%0d want 1 0 0 1 2",
               num_valid, key_out, mode_num_dis, busy, disp_sel);
    else n_pass++;
    step();
    n_checks++;
    if ({num_valid, key_out, mode_num_dis, busy} !== {1'b1, 4'd0, 1'b0, 1'b1})
      $display("FAIL inj_clr2: got nv=%b ko=%0d mnd=%b busy=%b want 1 0 0 1", num_valid, key_out, mode_num_dis, busy);
    else n_pass++;
    step();
    n_checks++;
    if ({num_valid, key_out, mode_num_dis, busy, disp_sel} !== {1'b1, 4'd3, 1'b0, 1'b1, 2'd0})
      $display("FAIL inj_digit: got nv=%b ko=%0d mnd=%b busy=%b disp=%0d want 1 3 0 1 0",
               num_valid, key_out, mode_num_dis, busy, disp_sel);
    else n_pass++;
    step();
    n_checks++;
    if ({num_valid, busy, disp_sel} !== {1'b0, 1'b0, 2'd0})
      $display("FAIL inj_done: got nv=%b busy=%b disp=%0d want 0 0 0", num_valid, busy, disp_sel);
    else n_pass++;
    press(4'd8);
    n_checks++;
    if ({num_valid, key_out} !== {1'b1, 4'd8}) $display("FAIL inj_second: got nv=%b ko=%0d want 1 8", num_valid, key_out);
    else n_pass++;
    press(4'd6);
    n_checks++;
    if (num_valid !== 1'b0) $display("FAIL inj_third: got nv=%b want 0", num_valid);
    else n_pass++;
  endtask

  task automatic test_digit_limit();
    do_reset();
    press(4'd9);
    n_checks++;
    if ({num_valid, key_out} !== {1'b1, 4'd9}) $display("FAIL limit_d1: got nv=%b ko=%0d want 1 9", num_valid, key_out);
    else n_pass++;
    press(4'd9);
    n_checks++;
    if ({num_valid, key_out} !== {1'b1, 4'd9}) $display("FAIL limit_d2: got nv=%b ko=%0d want 1 9", num_valid, key_out);
    else n_pass++;
    press(4'd5);
    n_checks++;
    if (num_valid !== 1'b0) $display("FAIL limit_d3: got nv=%b want 0", num_valid);
    else n_pass++;
  endtask

  task automatic test_drop_clr_b();
    do_reset();
    press(4'd5);
    press(4'd11);
    key_valid = 1'b1;
    key_code  = 4'd7;
    step();
    key_valid = 1'b0;
    key_code  = 4'd0;
    n_checks++;
    if ({key_drop, num_valid, key_out, busy} !== {1'b1, 1'b1, 4'd0, 1'b1})
      $display("FAIL drop_pulse: got kd=%b nv=%b ko=%0d busy=%b want 1 1 0 1", key_drop, num_valid, key_out, busy);
    else n_pass++;
    step();
    n_checks++;
    if ({key_drop, num_valid, busy, mode_num_dis, disp_sel, mode_arith} !== {1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1})
      $display("FAIL drop_after: got kd=%b nv=%b busy=%b mnd=%b disp=%0d ar=%0d want 0 0 0 1 1 1",
               key_drop, num_valid, busy, mode_num_dis, disp_sel, mode_arith);
    else n_pass++;
    step();
    n_checks++;
    if ({key_drop, num_valid} !== 2'b00) $display("FAIL drop_no_extra: got kd=%b nv=%b want 0 0", key_drop, num_valid);
    else n_pass++;
    press(4'd4);
    n_checks++;
    if ({num_valid, key_out, mode_num_dis} !== {1'b1, 4'd4, 1'b1})
      $display("FAIL drop_enter_b: got nv=%b ko=%0d mnd=%b want 1 4 1", num_valid, key_out, mode_num_dis);
    else n_pass++;
  endtask

  // Continues in S_ENTER_B left by test_drop_clr_b.
  task automatic test_op_overwrite_clear();
    press(4'd10);
    n_checks++;
    if ({mode_arith, busy, num_valid} !== {2'd0, 1'b0, 1'b0})
      $display("FAIL op_add: got ar=%0d busy=%b nv=%b want 0 0 0", mode_arith, busy, num_valid);
    else n_pass++;
    press(4'd11);
    n_checks++;
    if (mode_arith !== 2'd1) $display("FAIL op_sub: got ar=%0d want 1", mode_arith);
    else n_pass++;
    press(4'd12);
    n_checks++;
    if (mode_arith !== 2'd2) $display("FAIL op_mul: got ar=%0d want 2", mode_arith);
    else n_pass++;
    press(4'd13);
    n_checks++;
    if ({mode_arith, disp_sel} !== {2'd2, 2'd2}) $display("FAIL op_result: got ar=%0d disp=%0d want 2 2", mode_arith, disp_sel);
    else n_pass++;
    press(4'd15);
    n_checks++;
    if ({num_valid, key_out, mode_num_dis, busy} !== {1'b1, 4'd0, 1'b0, 1'b1})
      $display("FAIL clr_a1: got nv=%b ko=%0d mnd=%b busy=%b want 1 0 0 1", num_valid, key_out, mode_num_dis, busy);
    else n_pass++;
    step();
    n_checks++;
    if ({num_valid, key_out, busy} !== {1'b1, 4'd0, 1'b1})
      $display("FAIL clr_a2: got nv=%b ko=%0d busy=%b want 1 0 1", num_valid, key_out, busy);
    else n_pass++;
    step();
    n_checks++;
    if ({num_valid, busy, disp_sel, mode_num_dis, mode_arith} !== {1'b0, 1'b0, 2'd0, 1'b0, 2'd2})
      $display("FAIL clr_a_done: got nv=%b busy=%b disp=%0d mnd=%b ar=%0d want 0 0 0 0 2",
               num_valid, busy, disp_sel, mode_num_dis, mode_arith);
    else n_pass++;
    press(4'd14);
    n_checks++;
    if ({num_valid, busy, disp_sel, key_drop} !== {1'b0, 1'b0, 2'd0, 1'b0})
      $display("FAIL code14: got nv=%b busy=%b disp=%0d kd=%b want 0 0 0 0", num_valid, busy, disp_sel, key_drop);
    else n_pass++;
    press(4'd13);
    n_checks++;
    if ({num_valid, disp_sel} !== {1'b0, 2'd0}) $display("FAIL eq_in_a: got nv=%b disp=%0d want 0 0", num_valid, disp_sel);
    else n_pass++;
    press(4'd7);
    n_checks++;
    if ({num_valid, key_out, mode_num_dis} !== {1'b1, 4'd7, 1'b0})
      $display("FAIL a_after_clr: got nv=%b ko=%0d mnd=%b want 1 7 0", num_valid, key_out, mode_num_dis);
    else n_pass++;
  endtask

  task automatic goto_result();
    do_reset();
    press(4'd1);
    press(4'd10);
    step();
    step();
    press(4'd2);
    press(4'd13);
  endtask

`ifdef IDLE_TIMEOUT_EN
  task automatic test_timeout();
    goto_result();
    repeat (7) step();
    n_checks++;
    if ({busy, disp_sel} !== {1'b0, 2'd2}) $display("FAIL tmo_early: got busy=%b disp=%0d want 0 2", busy, disp_sel);
    else n_pass++;
    step();
    n_checks++;
    if ({busy, num_valid, key_out, mode_num_dis} !== {1'b1, 1'b1, 4'd0, 1'b0})
      $display("FAIL tmo_fire: got busy=%b nv=%b ko=%0d mnd=%b want 1 1 0 0", busy, num_valid, key_out, mode_num_dis);
    else n_pass++;
    step();
    step();
    n_checks++;
    if ({busy, num_valid, disp_sel} !== {1'b0, 1'b0, 2'd0})
      $display("FAIL tmo_done: got busy=%b nv=%b disp=%0d want 0 0 0", busy, num_valid, disp_sel);
    else n_pass++;
    // Key in the expiry cycle: the digit path (with injection) must win.
    goto_result();
    repeat (7) step();
    key_valid = 1'b1;
    key_code  = 4'd3;
    step();
    key_valid = 1'b0;
    key_code  = 4'd0;
    step();
    step();
    n_checks++;
    if ({num_valid, key_out, busy} !== {1'b1, 4'd3, 1'b1})
      $display("FAIL tmo_key_wins: got nv=%b ko=%0d busy=%b want 1 3 1", num_valid, key_out, busy);
    else n_pass++;
  endtask
`else
  task automatic test_result_hold();
    goto_result();
    repeat (20) step();
    n_checks++;
    if ({busy, num_valid, disp_sel} !== {1'b0, 1'b0, 2'd2})
      $display("FAIL result_hold: got busy=%b nv=%b disp=%0d want 0 0 2", busy, num_valid, disp_sel);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_calc();
    test_result_inject();
    test_digit_limit();
    test_drop_clr_b();
    test_op_overwrite_clear();
`ifdef IDLE_TIMEOUT_EN
    test_timeout();
`else
    test_result_hold();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
